// File: rtl/mux_rr_arb.sv
// -----------------------------------------------------------------------------
// mux_rr_arb
// N-channel, DATA_W-bit arbitrated multiplexer with a registered output stage.
// Several valid/ready producers share one valid/ready consumer.
// The winner is chosen combinationally, either round-robin or fixed priority
// (lowest index wins). The output register also records which channel won.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = round-robin, 1 = fixed priority
//   in_valid   per-channel valid (bit i = channel i)
//   in_data    packed data, channel i at [i*DATA_W +: DATA_W]
//   in_ready   per-channel ready, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_ch     index of the channel that produced out_data
//   out_ready  consumer accepts the word
// -----------------------------------------------------------------------------
module mux_rr_arb #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    input  logic                   out_ready
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SEL_W-1:0]   ch_q, ch_d;

    logic [N_CH-1:0]    ptr_mask_s;
    logic [N_CH-1:0]    upper_valid_s;
    logic [SEL_W-1:0]   winner_s;
    logic               any_valid_s;
    logic               load_en_s;
    logic               xfer_s;

    // Index of the lowest set bit of vec (0 when vec is empty; callers gate on that).
    function automatic logic [SEL_W-1:0] first_set(input logic [N_CH-1:0] vec);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SEL_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Mask of channel indices at or above ptr.
    // The round-robin scan checks these first and then wraps to the lowest index.
    // This avoids modular arithmetic for non-power-of-two channel counts.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ptr_mask_s[i] = (i >= int'(ptr_q));
        end
    end

    // Winner selection for both arbitration modes.
    always_comb begin
        upper_valid_s = in_valid & ptr_mask_s;
        any_valid_s   = |in_valid;
        if (mode == 1'b1) begin
            winner_s = first_set(in_valid);
        end else if (|upper_valid_s) begin
            winner_s = first_set(upper_valid_s);
        end else begin
            winner_s = first_set(in_valid);
        end
    end

    // Handshake: grant the winner only when the output register can take a word.
    // rst_n is included so that no ready is shown while reset is held.
    always_comb begin
        load_en_s = (state_q == ST_EMPTY) | out_ready;
        xfer_s    = load_en_s & any_valid_s & rst_n;
        if (xfer_s) begin
            in_ready = {{(N_CH-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            in_ready = '0;
        end
    end

    // Next-state logic for the output stage and the round-robin pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        ch_d    = ch_q;
        if (xfer_s) begin
            state_d = ST_FULL;
            data_d  = in_data[int'(winner_s)*DATA_W +: DATA_W];
            ch_d    = winner_s;
            if (mode == 1'b0) begin
                ptr_d = (winner_s == SEL_W'(N_CH - 1)) ? '0 : winner_s + SEL_W'(1);
            end else begin
                ptr_d = ptr_q;
            end
        end else if ((state_q == ST_FULL) && out_ready) begin
            // Drained with nothing to replace it; data and channel keep their values.
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
module tb_mux_rr_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT A: 8 channels x 8 bits
    logic        mode_a, out_ready_a, out_valid_a;
    logic [7:0]  in_valid_a, in_ready_a, out_data_a;
    logic [63:0] in_data_a;
    logic [2:0]  out_ch_a;
    logic [7:0]  dat_a [8];

    // DUT B: 5 channels x 16 bits
    logic        mode_b, out_ready_b, out_valid_b;
    logic [4:0]  in_valid_b, in_ready_b;
    logic [79:0] in_data_b;
    logic [15:0] out_data_b;
    logic [2:0]  out_ch_b;
    logic [15:0] dat_b [5];

    for (genvar g = 0; g < 8; g++) begin : g_pack_a
        assign in_data_a[g*8 +: 8] = dat_a[g];
    end
    for (genvar g = 0; g < 5; g++) begin : g_pack_b
        assign in_data_b[g*16 +: 16] = dat_b[g];
    end

    mux_rr_arb #(.N_CH(8), .DATA_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .in_valid(in_valid_a),
        .in_data(in_data_a), .in_ready(in_ready_a), .out_valid(out_valid_a),
        .out_data(out_data_a), .out_ch(out_ch_a), .out_ready(out_ready_a)
    );

    mux_rr_arb #(.N_CH(5), .DATA_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .out_valid(out_valid_b),
        .out_data(out_data_b), .out_ch(out_ch_b), .out_ready(out_ready_b)
    );

    typedef struct {
        int          ch;
        logic [15:0] data;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_ptr_a, m_ptr_b, m_ch_a, m_ch_b;
    bit          m_full_a, m_full_b;
    logic [15:0] m_dat_a, m_dat_b;
    logic [7:0]  exp_rdy_a, seen_rdy_a;
    logic [4:0]  exp_rdy_b, seen_rdy_b;

    // Reference arbiter: scan n channels upward from the start index, wrapping around.
    function automatic int pick(input logic [7:0] v, input int n, input int p, input logic md);
        int s;
        int c;
        s = md ? 0 : p;
        for (int k = 0; k < n; k++) begin
            c = (s + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full_a = 1'b0; m_ptr_a = 0; m_ch_a = 0; m_dat_a = 16'h0000; q_a.delete();
        m_full_b = 1'b0; m_ptr_b = 0; m_ch_b = 0; m_dat_b = 16'h0000; q_b.delete();
    endtask

    // Drive one cycle on DUT A, predict the grant, push the expected word, and clock.
    task automatic step_a(input logic [7:0] v, input logic md, input logic ordy);
        int   w;
        bit   le;
        exp_t e;
        in_valid_a = v; mode_a = md; out_ready_a = ordy;
        #1;
        seen_rdy_a = in_ready_a;
        w  = pick(v, 8, m_ptr_a, md);
        le = !m_full_a || ordy;
        exp_rdy_a = 8'h00;
        if (le && w >= 0) begin
            exp_rdy_a[w] = 1'b1;
            e.ch = w; e.data = {8'h00, dat_a[w]};
            q_a.push_back(e);
            m_full_a = 1'b1;
            if (!md) m_ptr_a = (w + 1) % 8;
        end else if (ordy) begin
            m_full_a = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // Drive one cycle on DUT B, predict the grant, push the expected word, and clock.
    task automatic step_b(input logic [4:0] v, input logic md, input logic ordy);
        int   w;
        bit   le;
        exp_t e;
        in_valid_b = v; mode_b = md; out_ready_b = ordy;
        #1;
        seen_rdy_b = in_ready_b;
        w  = pick({3'b000, v}, 5, m_ptr_b, md);
        le = !m_full_b || ordy;
        exp_rdy_b = 5'b00000;
        if (le && w >= 0) begin
            exp_rdy_b[w] = 1'b1;
            e.ch = w; e.data = dat_b[w];
            q_b.push_back(e);
            m_full_b = 1'b1;
            if (!md) m_ptr_b = (w + 1) % 5;
        end else if (ordy) begin
            m_full_b = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t e;
        in_valid_a = 8'hFF; out_ready_a = 1'b1; mode_a = 1'b0; rst_n = 1'b0;
        #3;
        n_tests++; if ({out_valid_a, out_ch_a, out_data_a, in_ready_a} !== 20'h0) begin n_fail++;
            $display("FAIL reset_hold: got v%b ch%0d d%h rdy%h want all 0", out_valid_a, out_ch_a, out_data_a, in_ready_a); end
        in_valid_a = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step_a(8'hFF, 1'b0, 1'b1);
            if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
            n_tests++; if ({out_valid_a, out_ch_a, out_data_a} !== {m_full_a, 3'(m_ch_a), m_dat_a[7:0]}) begin n_fail++;
                $display("FAIL reset_pre: got v%b ch%0d %h want v%b ch%0d %h", out_valid_a, out_ch_a, out_data_a, m_full_a, m_ch_a, m_dat_a[7:0]); end
        end
        #2; rst_n = 1'b0; #1;
        n_tests++; if ({out_valid_a, out_ch_a, out_data_a, in_ready_a} !== 20'h0) begin n_fail++;
            $display("FAIL reset_mid: got v%b ch%0d d%h rdy%h want all 0", out_valid_a, out_ch_a, out_data_a, in_ready_a); end
        model_reset();
        @(posedge clk);
        in_valid_a = 8'h00;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step_a(8'h01, 1'b0, 1'b1);
        if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
        n_tests++; if (seen_rdy_a !== exp_rdy_a) begin n_fail++;
            $display("FAIL reset_first_rdy: got %h want %h", seen_rdy_a, exp_rdy_a); end
        n_tests++; if (out_valid_a !== 1'b1 || out_ch_a !== 3'd0 || out_data_a !== dat_a[0]) begin n_fail++;
            $display("FAIL reset_first_grant: got v%b ch%0d %h want v1 ch0 %h", out_valid_a, out_ch_a, out_data_a, dat_a[0]); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   prev;
        prev = m_ch_a;
        for (int k = 0; k < 9; k++) begin
            step_a(8'hFF, 1'b0, 1'b1);
            n_tests++; if (seen_rdy_a !== exp_rdy_a) begin n_fail++;
                $display("FAIL rr_rdy: got %h want %h", seen_rdy_a, exp_rdy_a); end
            if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
            n_tests++; if ({out_valid_a, out_ch_a, out_data_a} !== {m_full_a, 3'(m_ch_a), m_dat_a[7:0]}) begin n_fail++;
                $display("FAIL rr_out: got v%b ch%0d %h want v%b ch%0d %h", out_valid_a, out_ch_a, out_data_a, m_full_a, m_ch_a, m_dat_a[7:0]); end
            n_tests++; if (out_ch_a !== 3'((prev + 1) % 8)) begin n_fail++;
                $display("FAIL rr_seq: got ch%0d want ch%0d", out_ch_a, (prev + 1) % 8); end
            prev = (prev + 1) % 8;
        end
    endtask

    task automatic test_fixed_priority();
        exp_t e;
        logic [7:0] v;
        int   want;
        for (int k = 0; k < 8; k++) begin
            v    = (k < 4) ? 8'b1010_0100 : 8'b1010_0000;
            want = (k < 4) ? 2 : 5;
            step_a(v, 1'b1, 1'b1);
            n_tests++; if (seen_rdy_a !== exp_rdy_a) begin n_fail++;
                $display("FAIL fp_rdy: got %h want %h", seen_rdy_a, exp_rdy_a); end
            if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
            n_tests++; if (out_valid_a !== 1'b1 || out_ch_a !== 3'(want) || out_data_a !== m_dat_a[7:0]) begin n_fail++;
                $display("FAIL fp_out: got v%b ch%0d %h want v1 ch%0d %h", out_valid_a, out_ch_a, out_data_a, want, m_dat_a[7:0]); end
        end
        // Back to round-robin: the grant resumes from the pointer left before fixed priority.
        for (int k = 0; k < 3; k++) begin
            step_a(8'hFF, 1'b0, 1'b1);
            n_tests++; if (seen_rdy_a !== exp_rdy_a) begin n_fail++;
                $display("FAIL fp_resume_rdy: got %h want %h", seen_rdy_a, exp_rdy_a); end
            if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
            n_tests++; if ({out_valid_a, out_ch_a, out_data_a} !== {m_full_a, 3'(m_ch_a), m_dat_a[7:0]}) begin n_fail++;
                $display("FAIL fp_resume: got v%b ch%0d %h want v%b ch%0d %h", out_valid_a, out_ch_a, out_data_a, m_full_a, m_ch_a, m_dat_a[7:0]); end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        dat_a[3] = 8'hA5;
        for (int k = 0; k < 7; k++) begin
            // Table: load ch3, stall 4 cycles, then release with everyone requesting.
            if (k == 0)     step_a(8'h08, 1'b0, 1'b1);
            else if (k < 5) step_a(8'hFF, 1'b0, 1'b0);
            else            step_a(8'hFF, 1'b0, 1'b1);
            n_tests++; if (seen_rdy_a !== exp_rdy_a) begin n_fail++;
                $display("FAIL bp_rdy%0d: got %h want %h", k, seen_rdy_a, exp_rdy_a); end
            if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
            n_tests++; if ({out_valid_a, out_ch_a, out_data_a} !== {m_full_a, 3'(m_ch_a), m_dat_a[7:0]}) begin n_fail++;
                $display("FAIL bp_out%0d: got v%b ch%0d %h want v%b ch%0d %h", k, out_valid_a, out_ch_a, out_data_a, m_full_a, m_ch_a, m_dat_a[7:0]); end
            if (k >= 1 && k <= 4) begin
                n_tests++; if (out_ch_a !== 3'd3 || out_data_a !== 8'hA5 || out_valid_a !== 1'b1) begin n_fail++;
                    $display("FAIL bp_hold%0d: got v%b ch%0d %h want v1 ch3 a5", k, out_valid_a, out_ch_a, out_data_a); end
            end
        end
    endtask

    task automatic test_drain();
        exp_t e;
        logic [7:0] v;
        for (int k = 0; k < 6; k++) begin
            v = (k == 2) ? 8'h02 : 8'h00;
            step_a(v, 1'b0, 1'b1);
            n_tests++; if (seen_rdy_a !== exp_rdy_a) begin n_fail++;
                $display("FAIL drain_rdy%0d: got %h want %h", k, seen_rdy_a, exp_rdy_a); end
            if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
            n_tests++; if ({out_valid_a, out_ch_a, out_data_a} !== {m_full_a, 3'(m_ch_a), m_dat_a[7:0]}) begin n_fail++;
                $display("FAIL drain_out%0d: got v%b ch%0d %h want v%b ch%0d %h", k, out_valid_a, out_ch_a, out_data_a, m_full_a, m_ch_a, m_dat_a[7:0]); end
            n_tests++; if (out_valid_a !== ((k == 2) ? 1'b1 : 1'b0)) begin n_fail++;
                $display("FAIL drain_pulse%0d: got v%b want v%b", k, out_valid_a, (k == 2)); end
        end
    endtask

    task automatic test_random_a();
        exp_t e;
        logic md;
        md = 1'b0;
        for (int k = 0; k < 120; k++) begin
            for (int i = 0; i < 8; i++) dat_a[i] = 8'($urandom);
            if ($urandom_range(0, 7) == 0) md = ~md;
            step_a(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), md, ($urandom_range(0, 3) != 0));
            n_tests++; if (seen_rdy_a !== exp_rdy_a) begin n_fail++;
                $display("FAIL rnd_a_rdy%0d: got %h want %h", k, seen_rdy_a, exp_rdy_a); end
            if (q_a.size() > 0) begin e = q_a.pop_front(); m_ch_a = e.ch; m_dat_a = e.data; end
            n_tests++; if ({out_valid_a, out_ch_a, out_data_a} !== {m_full_a, 3'(m_ch_a), m_dat_a[7:0]}) begin n_fail++;
                $display("FAIL rnd_a_out%0d: got v%b ch%0d %h want v%b ch%0d %h", k, out_valid_a, out_ch_a, out_data_a, m_full_a, m_ch_a, m_dat_a[7:0]); end
        end
        in_valid_a = 8'h00;
    endtask

    task automatic test_npot_wrap();
        exp_t e;
        int   prev;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            step_b(5'b10001, 1'b0, 1'b1);
            n_tests++; if (seen_rdy_b !== exp_rdy_b) begin n_fail++;
                $display("FAIL npot_rdy: got %b want %b", seen_rdy_b, exp_rdy_b); end
            if (q_b.size() > 0) begin e = q_b.pop_front(); m_ch_b = e.ch; m_dat_b = e.data; end
            n_tests++; if ({out_valid_b, out_ch_b, out_data_b} !== {m_full_b, 3'(m_ch_b), m_dat_b}) begin n_fail++;
                $display("FAIL npot_out: got v%b ch%0d %h want v%b ch%0d %h", out_valid_b, out_ch_b, out_data_b, m_full_b, m_ch_b, m_dat_b); end
            n_tests++; if ((out_ch_b !== 3'd0 && out_ch_b !== 3'd4) || int'(out_ch_b) == prev) begin n_fail++;
                $display("FAIL npot_alt: got ch%0d after ch%0d want alternating 0/4", out_ch_b, prev); end
            n_tests++; if (dut_b.ptr_q > 3'd4) begin n_fail++;
                $display("FAIL npot_ptr: got %0d want 0..4", dut_b.ptr_q); end
            prev = int'(out_ch_b);
        end
    endtask

    task automatic test_random_b();
        exp_t e;
        logic md;
        md = 1'b0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 5; i++) dat_b[i] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) md = ~md;
            step_b(5'($urandom), md, ($urandom_range(0, 3) != 0));
            n_tests++; if (seen_rdy_b !== exp_rdy_b) begin n_fail++;
                $display("FAIL rnd_b_rdy%0d: got %b want %b", k, seen_rdy_b, exp_rdy_b); end
            if (q_b.size() > 0) begin e = q_b.pop_front(); m_ch_b = e.ch; m_dat_b = e.data; end
            n_tests++; if ({out_valid_b, out_ch_b, out_data_b} !== {m_full_b, 3'(m_ch_b), m_dat_b}) begin n_fail++;
                $display("FAIL rnd_b_out%0d: got v%b ch%0d %h want v%b ch%0d %h", k, out_valid_b, out_ch_b, out_data_b, m_full_b, m_ch_b, m_dat_b); end
            n_tests++; if (dut_b.ptr_q > 3'd4) begin n_fail++;
                $display("FAIL rnd_b_ptr%0d: got %0d want 0..4", k, dut_b.ptr_q); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode_a = 1'b0; out_ready_a = 1'b1; in_valid_a = 8'h00;
        mode_b = 1'b0; out_ready_b = 1'b1; in_valid_b = 5'b00000;
        for (int i = 0; i < 8; i++) dat_a[i] = 8'(8'h30 + i);
        for (int i = 0; i < 5; i++) dat_b[i] = 16'(16'hC000 + 16'h0101 * i);
        model_reset();
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_drain();
        test_random_a();
        test_npot_wrap();
        test_random_b();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
